topk_drain: RTL

Streaming top-K collector with a serialized readout port. Accepts unsigned samples on a valid/ready input stream and keeps the K largest values seen, sorted, in an internal register array. On a flush request it stops accepting input and emits the stored values largest-first over a valid/ready output stream with a last marker, then clears itself for the next batch. It sits downstream of the sample-statistics blocks, such as the second-largest tracker, and exports full ranked results to a consumer instead of a single scalar.

---
 rtl/topk_drain.sv | 101 ++++++++++
 1 files changed

// File: rtl/topk_drain.sv
// Streaming top-K collector: keeps the K largest unsigned samples sorted, then
// drains them largest-first over a valid/ready port with a last marker.
module topk_drain #(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned K          = 4,
  localparam int unsigned CW         = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  din_ready,
  input  logic                  flush,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_last,
  input  logic                  dout_ready,
  output logic [CW-1:0]         count
);

  typedef enum logic [0:0] {StFill, StDrain} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] entry_q [K];
  logic [DATA_WIDTH-1:0] entry_d [K];
  logic [DATA_WIDTH-1:0] ins     [K];
  logic [DATA_WIDTH-1:0] shifted [K];
  logic [CW-1:0]         count_q, count_d, count_inc;
  logic [K-1:0]          mask;

  always_comb begin
    // mask[i]: din belongs at or above index i; unoccupied slots always take a shift.
    mask = '0;
    for (int i = 0; i < K; i++) begin
      mask[i] = (CW'(i) < count_q) ? (din > entry_q[i]) : 1'b1;
    end
    ins[0] = mask[0] ? din : entry_q[0];
    for (int i = 1; i < K; i++) begin
      ins[i] = mask[i] ? (mask[i-1] ? entry_q[i-1] : din) : entry_q[i];
    end
    for (int i = 0; i < K - 1; i++) begin
      shifted[i] = entry_q[i+1];
    end
    shifted[K-1] = '0;
    count_inc = (count_q == CW'(K)) ? count_q : count_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    entry_d = entry_q;
    unique case (state_q)
      StFill: begin
        if (din_valid) begin
          entry_d = ins;
          count_d = count_inc;
        end
        if (flush && (count_d != '0)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (dout_ready) begin
          entry_d = shifted;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = StFill;
            for (int i = 0; i < K; i++) begin
              entry_d[i] = '0;
            end
            count_d = '0;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StFill;
      count_q <= '0;
      for (int i = 0; i < K; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int i = 0; i < K; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign din_ready  = (state_q == StFill);
  assign dout_valid = (state_q == StDrain);
  assign dout       = dout_valid ? entry_q[0] : '0;
  assign dout_last  = dout_valid && (count_q == CW'(1));
  assign count      = count_q;

endmodule
